serial_shift_unit: RTL and testbench
====================================

# serial_shift_unit

Multi-cycle, one-bit-per-cycle shift unit that performs the opposite-direction shifts to the single-cycle ALU shifter: logical right, left, and rotate left. It accepts an operand, mode and amount with a start/done handshake. It shifts a working register one position per clock. It returns a registered 16-bit result. It sits beside the ALU for instructions and microcode sequences that need SRL/ROL.

## Interface
- WIDTH, 16: data width in bits.
- CNT_W, 4: shift-amount width; the maximum amount is 2^CNT_W-1.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- Start  in  1  request; sampled only when the unit is accepting (see Operation).
- Shift_In  in  WIDTH  operand; sampled on the accepting Start edge.
- Shift_Val  in  CNT_W  shift amount; sampled with Shift_In.
- Mode  in  2  00 = SRL (zero-fill from MSB), 01 = SLL (zero-fill LSB), 1x = ROL (MSB wraps to LSB); sampled with Shift_In.
- Shift_Out  out  WIDTH  last completed result; registered.
- Zero  out  1  high when Shift_Out == 0; registered together with Shift_Out.
- Busy  out  1  high while in SHIFT.
- Done  out  1  one-cycle pulse; Shift_Out is valid and new in this cycle.

## Operation
- Internal state: FSM (IDLE, SHIFT, DONE), working register data[WIDTH-1:0], counter cnt[CNT_W-1:0], latched mode[1:0].
- Accepting condition: state is IDLE or DONE, and Start = 1.
- In IDLE or DONE, on Start:
  - data <= Shift_In, cnt <= Shift_Val, mode <= Mode.
  - If Shift_Val != 0: go to SHIFT.
  - If Shift_Val == 0: go to DONE, and load Shift_Out <= Shift_In and Zero <= (Shift_In == 0) on the same edge.
- Per edge in SHIFT, data is replaced by one step:
  - SRL: {1'b0, data[WIDTH-1:1]}.
  - SLL: {data[WIDTH-2:0], 1'b0}.
  - ROL: {data[WIDTH-2:0], data[WIDTH-1]}.
- Also per edge in SHIFT: cnt <= cnt - 1.
  - When cnt == 1 at that edge, go to DONE.
  - On that same edge, load Shift_Out with the shifted value and Zero with (shifted value == 0).
- IDLE without Start: stay. DONE without Start: go to IDLE.
- Start while in SHIFT is ignored; there is no queueing and no error flag. Shift_In, Shift_Val and Mode may change freely after the accepting edge.
- Shift_Out and Zero change only on entry to DONE. They hold their value through IDLE and through the SHIFT phase of a later operation.
- Amount arithmetic is unsigned. The counter never wraps, because SHIFT is entered only with cnt >= 1.
- ROL by an amount that is a multiple of WIDTH is impossible for WIDTH=16, CNT_W=4. The maximum amount is 15.
- Done = (state == DONE). Busy = (state == SHIFT).

## Timing
- Reset values: state IDLE, Shift_Out 0, Zero 1, Busy 0, Done 0, data 0, cnt 0, mode 00.
- Let E0 be the accepting Start edge and N = Shift_Val.
  - Busy is high for exactly N cycles, starting in the cycle after E0.
  - Done is high for exactly one cycle, the cycle after edge E(N). Latency from Start to Done is N+1 cycles.
  - N = 0 gives Done in the cycle immediately after E0, with Busy never asserting.
- Back-to-back operation: Start held high in the DONE cycle is accepted.
  - DONE goes to SHIFT (or to DONE again if the new N = 0), with no idle cycle.
  - Consecutive N = 0 requests give a Done pulse on every cycle.
- rst has priority over every event, including Start on the same edge. If rst is asserted mid-SHIFT or in DONE:
  - All state returns to reset values on that edge.
  - No Done is produced for the aborted operation.
  - Shift_Out becomes 0 and Zero becomes 1.

## Test plan
- Reset, then Start with SRL, Shift_In=0x8001, Shift_Val=4 -> Busy high for 4 cycles, Done in cycle 5 after E0, Shift_Out=0x0800, Zero=0.
- SLL, 0x00F1, amount 15 -> Done after 16 cycles, Shift_Out=0x8000. Then ROL, 0x1234, amount 4 -> 0x2341. Then ROL, 0x8001, amount 1 -> 0x0003.
- Shift_Val=0, Mode=ROL, Shift_In=0xBEEF -> Done one cycle after E0, Busy never high, Shift_Out=0xBEEF. Then SRL, 0x0001, amount 1 -> Shift_Out=0x0000, Zero=1.
- Start SLL, 0x0001, amount 8; pulse Start with different operands during Busy -> the extra Start is ignored, result 0x0100. Shift_Out keeps its previous value until Done.
- Hold Start high through the DONE cycle with a new request (SRL, 0xFFFF, amount 2) -> second operation is accepted with no idle cycle, result 0x3FFF, two separate Done pulses.
- Assert rst for one cycle in the middle of an amount-10 SHIFT -> next cycle state IDLE, Busy=0, Done=0, Shift_Out=0, Zero=1, and no Done pulse follows.

Source files
------------

// File: rtl/serial_shift_unit_if.sv
// +----------------------------------------------------------------------+
// | serial_shift_unit_if : request/result bus of the serial shift unit   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

interface serial_shift_unit_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
);
  logic             Start;
  logic [WIDTH-1:0] Shift_In;
  logic [CNT_W-1:0] Shift_Val;
  logic [1:0]       Mode;
  logic [WIDTH-1:0] Shift_Out;
  logic             Zero;
  logic             Busy;
  logic             Done;

  modport master (
    output Start, Shift_In, Shift_Val, Mode,
    input  Shift_Out, Zero, Busy, Done
  );

  modport slave (
    input  Start, Shift_In, Shift_Val, Mode,
    output Shift_Out, Zero, Busy, Done
  );
endinterface

`default_nettype wire

// File: rtl/serial_shift_unit.sv
// +----------------------------------------------------------------------+
// | serial_shift_unit : one-bit-per-cycle SRL / SLL / ROL shifter        |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module serial_shift_unit #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  wire                  clk,
  input  wire                  rst,
  serial_shift_unit_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] MODE_SRL = 2'b00;
  localparam logic [1:0] MODE_SLL = 2'b01;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] data, data_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       mode, mode_nxt;
  logic [WIDTH-1:0] result, result_nxt;
  logic             zero, zero_nxt;
  logic [WIDTH-1:0] stepped;

  // Single-position step of the working register for the latched mode.
  always_comb begin
    case (mode)
      MODE_SRL: stepped = {1'b0, data[WIDTH-1:1]};
      MODE_SLL: stepped = {data[WIDTH-2:0], 1'b0};
      default:  stepped = {data[WIDTH-2:0], data[WIDTH-1]};
    endcase
  end

  always_comb begin
    state_nxt  = state;
    data_nxt   = data;
    cnt_nxt    = cnt;
    mode_nxt   = mode;
    result_nxt = result;
    zero_nxt   = zero;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (bus.Start) begin
          data_nxt = bus.Shift_In;
          cnt_nxt  = bus.Shift_Val;
          mode_nxt = bus.Mode;
          if (bus.Shift_Val != '0) begin
            state_nxt = ST_SHIFT;
          end else begin
            state_nxt  = ST_DONE;
            result_nxt = bus.Shift_In;
            zero_nxt   = (bus.Shift_In == '0);
          end
        end else if (state == ST_DONE) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        data_nxt = stepped;
        cnt_nxt  = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_nxt  = ST_DONE;
          result_nxt = stepped;
          zero_nxt   = (stepped == '0);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      data   <= '0;
      cnt    <= '0;
      mode   <= 2'b00;
      result <= '0;
      zero   <= 1'b1;
    end else begin
      state  <= state_nxt;
      data   <= data_nxt;
      cnt    <= cnt_nxt;
      mode   <= mode_nxt;
      result <= result_nxt;
      zero   <= zero_nxt;
    end
  end

  assign bus.Shift_Out = result;
  assign bus.Zero      = zero;
  assign bus.Busy      = (state == ST_SHIFT);
  assign bus.Done      = (state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_serial_shift_unit.sv
// +----------------------------------------------------------------------+
// | tb_serial_shift_unit : self-checking bench for serial_shift_unit     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_serial_shift_unit;

  localparam int WIDTH = 16;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_shift_unit_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  serial_shift_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] din;
    logic [3:0]  amt;
    logic [15:0] exp;
  } vec_t;

  int errors = 0;
  int checks = 0;
  logic [15:0] last_exp = 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Reference: whole-word shifts by the full amount at once.
  function automatic logic [15:0] ref_shift(input logic [1:0] m, input logic [15:0] d, input logic [3:0] a);
    logic [31:0] dbl;
    if (m == 2'b00) return d >> a;
    if (m == 2'b01) return 16'(d << a);
    dbl = {d, d} << a;
    return dbl[31:16];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request from the current sample point and follows it to Done.
  task automatic op(input logic [1:0] m, input logic [15:0] d, input logic [3:0] a,
                    input logic [15:0] expv, input int glitch, input string name);
    int cyc;
    int busy_cnt;
    logic held;
    bus.Start = 1'b1; bus.Mode = m; bus.Shift_In = d; bus.Shift_Val = a;
    tick();
    bus.Start = 1'b0;
    bus.Shift_In = 16'($urandom); bus.Shift_Val = 4'($urandom); bus.Mode = 2'($urandom);
    cyc = 1; busy_cnt = 0; held = 1'b1;
    while (!bus.Done && cyc < 40) begin
      if (bus.Busy) busy_cnt++;
      if (bus.Shift_Out !== last_exp) held = 1'b0;
      if (cyc == glitch) begin
        bus.Start = 1'b1; bus.Shift_In = 16'hA5A5; bus.Shift_Val = 4'd3; bus.Mode = 2'b10;
      end else begin
        bus.Start = 1'b0;
      end
      tick();
      cyc++;
    end
    bus.Start = 1'b0;
    check({name, " latency"}, cyc, a + 1);
    check({name, " busy_cycles"}, busy_cnt, a);
    check({name, " result"}, bus.Shift_Out, expv);
    check({name, " zero"}, bus.Zero, (expv == 16'h0000));
    check({name, " busy_at_done"}, bus.Busy, 1'b0);
    if (a != 0) check({name, " result_held"}, held, 1'b1);
    last_exp = expv;
  endtask

  task automatic idle_check(input string name);
    tick();
    check({name, " done_pulse_len"}, bus.Done, 1'b0);
    check({name, " idle_busy"}, bus.Busy, 1'b0);
    check({name, " idle_hold"}, bus.Shift_Out, last_exp);
  endtask

  vec_t vecs[9];

  initial begin
    bus.Start = 1'b0; bus.Shift_In = '0; bus.Shift_Val = '0; bus.Mode = 2'b00;
    vecs[0] = '{2'b00, 16'h8001, 4'd4,  16'h0800};
    vecs[1] = '{2'b01, 16'h00F1, 4'd15, 16'h8000};
    vecs[2] = '{2'b10, 16'h1234, 4'd4,  16'h2341};
    vecs[3] = '{2'b10, 16'h8001, 4'd1,  16'h0003};
    vecs[4] = '{2'b10, 16'hBEEF, 4'd0,  16'hBEEF};
    vecs[5] = '{2'b00, 16'h0001, 4'd1,  16'h0000};
    vecs[6] = '{2'b11, 16'hF00F, 4'd8,  16'h0FF0};
    vecs[7] = '{2'b01, 16'h0000, 4'd0,  16'h0000};
    vecs[8] = '{2'b00, 16'hFFFF, 4'd2,  16'h3FFF};

    tick(); tick();
    rst = 1'b0;
    check("reset shift_out", bus.Shift_Out, 16'h0000);
    check("reset zero", bus.Zero, 1'b1);
    check("reset busy", bus.Busy, 1'b0);
    check("reset done", bus.Done, 1'b0);

    // Table vectors, each one started in the Done cycle of the previous.
    for (int i = 0; i < 9; i++) begin
      op(vecs[i].mode, vecs[i].din, vecs[i].amt, vecs[i].exp, 0, $sformatf("vec%0d", i));
    end
    idle_check("table_end");

    // Start pulsed during Busy must be ignored.
    op(2'b01, 16'h0001, 4'd8, 16'h0100, 3, "ignore_start");
    idle_check("ignore_start");

    // Back-to-back zero-amount requests: Done on every cycle.
    op(2'b00, 16'h1111, 4'd0, 16'h1111, 0, "zero_a");
    op(2'b01, 16'h2222, 4'd0, 16'h2222, 0, "zero_b");
    op(2'b10, 16'h0000, 4'd0, 16'h0000, 0, "zero_c");
    idle_check("zero_end");

    // Randomised operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  m;
      logic [15:0] d;
      logic [3:0]  a;
      m = 2'($urandom); d = 16'($urandom); a = 4'($urandom);
      if ($urandom_range(0, 3) == 0) d = 16'h0001 << $urandom_range(0, 15);
      op(m, d, a, ref_shift(m, d, a), 0, $sformatf("rnd%0d", i));
      if ($urandom_range(0, 1) == 1) idle_check($sformatf("rnd%0d", i));
    end

    // Reset in the middle of an amount-10 shift aborts with no Done.
    op(2'b10, 16'hCAFE, 4'd0, 16'hCAFE, 0, "pre_abort");
    bus.Start = 1'b1; bus.Mode = 2'b01; bus.Shift_In = 16'h00FF; bus.Shift_Val = 4'd10;
    tick();
    bus.Start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("abort busy_before", bus.Busy, 1'b1);
    check("abort hold_before", bus.Shift_Out, 16'hCAFE);
    rst = 1'b1;
    bus.Start = 1'b1; bus.Shift_Val = 4'd0;
    tick();
    rst = 1'b0;
    bus.Start = 1'b0;
    check("abort busy", bus.Busy, 1'b0);
    check("abort done", bus.Done, 1'b0);
    check("abort shift_out", bus.Shift_Out, 16'h0000);
    check("abort zero", bus.Zero, 1'b1);
    begin
      int dones = 0;
      for (int i = 0; i < 15; i++) begin
        tick();
        if (bus.Done || bus.Busy) dones++;
      end
      check("abort no_done", dones, 0);
    end
    last_exp = 16'h0000;

    // Unit still works after the abort, starting from IDLE.
    op(2'b00, 16'h8000, 4'd15, 16'h0001, 0, "post_abort");
    idle_check("post_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
